// File: rtl/calc_disp_pkg.sv
// Shared constants, types and helpers for the calculator display path.
package calc_disp_pkg;

    // Display geometry and converter widths
    localparam int N_DIG  = 8;
    localparam int BIN_W  = 25;
    localparam int BCD_W  = 4 * N_DIG;
    localparam int ITER_W = $clog2(BIN_W);

    // Non-numeric digit codes; 0..9 encode themselves
    localparam logic [3:0] DIG_BLANK = 4'hA;
    localparam logic [3:0] DIG_DASH  = 4'hB;
    localparam logic [3:0] DIG_E     = 4'hC;

    // Conversion sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FIX  = 2'd2
    } state_t;

    // One 4-bit code per digit, digit 0 is the rightmost
    typedef logic [N_DIG-1:0][3:0] dig_vec_t;

    // Result of the FIX step: what the display should show
    typedef struct packed {
        dig_vec_t codes;
        logic     err;
    } disp_res_t;

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
    function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < N_DIG; i++) begin
            if (b[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Digit code to active-low 7-segment pattern; dp is always off.
module seg7_decode
    import calc_disp_pkg::*;
(
    input  logic [3:0] code,
    output logic [7:0] seg
);

    // Pattern bits are {dp, g, f, e, d, c, b, a}, all active-low
    always_comb begin
        seg = 8'hFF;
        case (code)
            4'd0:      seg = 8'hC0;
            4'd1:      seg = 8'hF9;
            4'd2:      seg = 8'hA4;
            4'd3:      seg = 8'hB0;
            4'd4:      seg = 8'h99;
            4'd5:      seg = 8'h92;
            4'd6:      seg = 8'h82;
            4'd7:      seg = 8'hF8;
            4'd8:      seg = 8'h80;
            4'd9:      seg = 8'h90;
            DIG_BLANK: seg = 8'hFF;
            DIG_DASH:  seg = 8'hBF;
            DIG_E:     seg = 8'h86;
            default:   seg = 8'hFF;
        endcase
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Result display controller: binary-to-BCD conversion, blanking/sign
// placement, and a free-running 8-digit multiplexed scan.
module disp_scan_ctrl
    import calc_disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [BIN_W-1:0] abs_num,
    input  logic             neg,
    output logic             busy,
    output logic             err,
    output logic [7:0]       an,
    output logic [7:0]       seg
);

    localparam int                DIV_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [ITER_W-1:0] CONV_LAST = ITER_W'(BIN_W - 1);

    state_t              state;
    logic [BIN_W-1:0]    bin_sr;
    logic [BCD_W-1:0]    bcd;
    logic [BCD_W-1:0]    bcd_adj;
    logic                neg_q;
    logic [ITER_W-1:0]   iter;
    dig_vec_t            codes;
    disp_res_t           fix_res;

    logic [DIV_W-1:0]    div;
    logic [2:0]          idx;
    logic [2:0]          idx_nxt;
    logic [7:0]          seg_nxt;

    // Correction step applied to the accumulator each CONV cycle
    always_comb bcd_adj = add3_nibbles(bcd);

    // FIX: blank leading zeros, place the sign, flag values that need a 9th digit
    always_comb begin
        logic [2:0] msd;
        logic       nz;
        msd           = 3'd0;
        nz            = 1'b0;
        fix_res.codes = {N_DIG{DIG_BLANK}};
        fix_res.err   = 1'b0;
        for (int i = 0; i < N_DIG; i++) begin
            if (bcd[i*4 +: 4] != 4'd0) begin
                msd = 3'(i);
                nz  = 1'b1;
            end
        end
        if (!nz) begin
            // Zero magnitude: a lone minus shows just the dash
            fix_res.codes[0] = neg_q ? DIG_DASH : 4'd0;
        end else if (neg_q && msd == 3'(N_DIG - 1)) begin
            // Sign would land beyond the leftmost digit
            fix_res.err      = 1'b1;
            fix_res.codes[0] = DIG_E;
        end else begin
            for (int i = 0; i < N_DIG; i++) begin
                if (i <= int'(msd))
                    fix_res.codes[i] = bcd[i*4 +: 4];
            end
            if (neg_q)
                fix_res.codes[msd + 3'd1] = DIG_DASH;
        end
    end

    // Conversion sequencer; display codes and err only change in FIX
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            err    <= 1'b0;
            codes  <= {N_DIG{DIG_BLANK}};
            bin_sr <= '0;
            bcd    <= '0;
            neg_q  <= 1'b0;
            iter   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        bin_sr <= abs_num;
                        neg_q  <= neg;
                        bcd    <= '0;
                        iter   <= '0;
                        busy   <= 1'b1;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    {bcd, bin_sr} <= {bcd_adj[BCD_W-2:0], bin_sr, 1'b0};
                    iter          <= iter + 1'b1;
                    if (iter == CONV_LAST)
                        state <= FIX;
                end
                FIX: begin
                    codes <= fix_res.codes;
                    err   <= fix_res.err;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign idx_nxt = idx + 3'd1;

    seg7_decode u_dec (
        .code (codes[idx_nxt]),
        .seg  (seg_nxt)
    );

    // Digit scan: an/seg are reloaded together when the divider wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            idx <= 3'd0;
            an  <= 8'hFE;
            seg <= 8'hFF;
        end else if (div == DIV_LAST) begin
            div <= '0;
            idx <= idx_nxt;
            an  <= ~(8'b1 << idx_nxt);
            seg <= seg_nxt;
        end else begin
            div <= div + 1'b1;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl with a string-based decimal model.
module tb_disp_scan_ctrl;

    localparam int SCAN_DIV = 4;
    localparam int LAT      = 26;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [24:0] abs_num = '0;
    logic        neg = 1'b0;
    logic        busy, err;
    logic [7:0]  an, seg;

    int checks = 0;
    int errors = 0;

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    logic [7:0] m_seg [8];
    bit         m_err;
    bit         prev_err;

    always #5 clk = ~clk;

    disp_scan_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .abs_num (abs_num),
        .neg     (neg),
        .busy    (busy),
        .err     (err),
        .an      (an),
        .seg     (seg)
    );

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
        $fatal(1);
    end

    // Expected display from the printed decimal text, right-aligned
    task automatic model(input int unsigned mag, input bit ng);
        string s;
        byte   c;
        s = $sformatf("%0d", mag);
        if (ng) begin
            if (mag == 0) s = "-";
            else          s = {"-", s};
        end
        for (int i = 0; i < 8; i++) m_seg[i] = 8'hFF;
        m_err = (s.len() > 8);
        if (m_err) begin
            m_seg[0] = 8'h86;
        end else begin
            for (int i = 0; i < s.len(); i++) begin
                c = s[s.len() - 1 - i];
                if (c == "-") m_seg[i] = 8'hBF;
                else          m_seg[i] = seg_tab[int'(c) - 48];
            end
        end
    endtask

    task automatic model_blank();
        for (int i = 0; i < 8; i++) m_seg[i] = 8'hFF;
        m_err = 1'b0;
    endtask

    // Strobe load at the next edge, then count cycles busy stays high
    task automatic do_load(input int unsigned val, input bit ng, output int cyc);
        abs_num = 25'(val);
        neg     = ng;
        load    = 1'b1;
        @(negedge clk);
        load = 1'b0;
        cyc  = 0;
        while (busy && cyc < 200) begin
            cyc++;
            checks++;
            if (err !== prev_err) begin
                errors++;
                $display("FAIL err_hold: err=%0b during conversion, required %0b", err, prev_err);
            end
            @(negedge clk);
        end
    endtask

    task automatic check_latency(input string name, input int cyc);
        checks++;
        if (cyc !== LAT) begin
            errors++;
            $display("FAIL %s_busy_cycles: busy high %0d cycles, required %0d", name, cyc, LAT);
        end
    endtask

    // Let every digit refresh, then compare one full scan against the model
    task automatic check_display(input string name);
        int idx;
        checks++;
        if (err !== m_err) begin
            errors++;
            $display("FAIL %s_err: err=%0b, required %0b", name, err, m_err);
        end
        repeat (8 * SCAN_DIV) @(negedge clk);
        for (int t = 0; t < 8 * SCAN_DIV; t++) begin
            idx = -1;
            for (int i = 0; i < 8; i++)
                if (an == ~(8'b1 << i)) idx = i;
            checks++;
            if (idx < 0) begin
                errors++;
                $display("FAIL %s_an: an=%h is not a single active-low enable", name, an);
            end else if (seg !== m_seg[idx]) begin
                errors++;
                $display("FAIL %s_seg: digit %0d seg=%h, required %h", name, idx, seg, m_seg[idx]);
            end
            @(negedge clk);
        end
        prev_err = m_err;
    endtask

    task automatic run_value(input string name, input int unsigned val, input bit ng);
        int cyc;
        model(val, ng);
        do_load(val, ng, cyc);
        check_latency(name, cyc);
        check_display(name);
    endtask

    task automatic test_reset();
        logic [7:0] exp_an;
        @(negedge clk);
        rst  = 1'b1;
        load = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        prev_err = 1'b0;
        checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%0b err=%0b, required 0 0", busy, err);
        end
        for (int t = 0; t < 9 * SCAN_DIV; t++) begin
            exp_an = ~(8'b1 << ((t / SCAN_DIV) % 8));
            checks++;
            if (an !== exp_an || seg !== 8'hFF || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_scan: t=%0d an=%h seg=%h busy=%0b, required an=%h seg=ff busy=0",
                         t, an, seg, busy, exp_an);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_basic();
        run_value("basic_1234", 1234, 1'b0);
    endtask

    task automatic test_boundaries();
        run_value("ovf_neg", 16777216, 1'b1);
        run_value("max_neg7", 9999999, 1'b1);
        run_value("max_pos", 16777216, 1'b0);
        run_value("neg_zero", 0, 1'b1);
        run_value("pos_zero", 0, 1'b0);
    endtask

    task automatic test_ignored_load();
        int cyc;
        model(8765, 1'b1);
        abs_num = 25'd8765;
        neg     = 1'b1;
        load    = 1'b1;
        @(negedge clk);
        load = 1'b0;
        cyc  = 0;
        while (busy && cyc < 200) begin
            cyc++;
            if (cyc == 5) begin
                abs_num = 25'd31;
                neg     = 1'b0;
                load    = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        check_latency("ignored_load", cyc);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_load_requeue: busy=%0b after first conversion, required 0", busy);
        end
        check_display("ignored_load");
    endtask

    task automatic test_back_to_back();
        int cyc;
        model(505, 1'b0);
        do_load(505, 1'b0, cyc);
        check_latency("b2b_first", cyc);
        prev_err = m_err;
        model(777, 1'b1);
        do_load(777, 1'b1, cyc);
        check_latency("b2b_second", cyc);
        check_display("b2b_second");
    endtask

    task automatic test_reset_mid_conv();
        run_value("pre_rst_ovf", 16777216, 1'b1);
        abs_num = 25'd555;
        neg     = 1'b0;
        load    = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || err !== 1'b0 || an !== 8'hFE || seg !== 8'hFF) begin
            errors++;
            $display("FAIL rst_mid_conv: busy=%0b err=%0b an=%h seg=%h, required 0 0 fe ff",
                     busy, err, an, seg);
        end
        prev_err = 1'b0;
        model_blank();
        check_display("rst_blank");
        run_value("after_rst_42", 42, 1'b0);
    endtask

    task automatic test_load_with_rst();
        abs_num = 25'd99;
        neg     = 1'b0;
        load    = 1'b1;
        rst     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        rst  = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL load_rst: busy=%0b after load with reset, required 0", busy);
        end
        prev_err = 1'b0;
        model_blank();
        check_display("load_rst");
    endtask

    task automatic test_random();
        int unsigned val;
        bit          ng;
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0:       val = $urandom_range(0, 16777216);
                1:       val = $urandom_range(0, 99);
                2:       val = (10 ** $urandom_range(0, 7)) - $urandom_range(0, 1);
                default: val = 16777216 - $urandom_range(0, 20000000 - 16777216);
            endcase
            if (val > 16777216) val = 16777216;
            ng = 1'($urandom_range(0, 1));
            run_value($sformatf("rand%0d", n), val, ng);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_ignored_load();
        test_back_to_back();
        test_reset_mid_conv();
        test_load_with_rst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Display controller for the calculator result path. It sits downstream of the registered magnitude/sign stage and accepts a 25-bit magnitude plus negative flag on a load strobe. It converts the magnitude to 8 BCD digits with a sequential shift-add-3 (double-dabble) engine, then applies leading-zero blanking and sign placement. It drives an 8-digit, time-multiplexed, common-anode 7-segment display.

## Interface

Parameters:
- `SCAN_DIV`, default 50000: clock cycles each digit is enabled; legal range ≥2.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset; one clock, synchronous, active-high.
- `load` in 1: one-cycle strobe; capture `abs_num`/`neg`.
- `abs_num` in 25: unsigned magnitude, 0..16_777_216.
- `neg` in 1: value is negative (also set for lone minus entry with magnitude 0).
- `busy` out 1: conversion in progress.
- `err` out 1: current value cannot be displayed.
- `an` out 8: digit enables, active-low, one-hot; bit 0 = rightmost digit.
- `seg` out 8: segments active-low, [6:0] = g..a, [7] = dp (always 1).

## Operation

- FSM states: IDLE, CONV, FIX.
- IDLE: `load`=1 captures `abs_num`/`neg` into a shift register, clears BCD accumulator, goes to CONV.
- CONV: 25 iterations; each cycle adds 3 to every BCD nibble ≥5, then shifts {bcd, bin} left 1. Iteration counter 0..24; at 24 go to FIX.
- FIX: computes display codes and updates display registers atomically; returns to IDLE.
- `load` outside IDLE is ignored (not queued).
- Display registers hold the previous value until FIX; no partial result is ever visible.
- Digit codes: 0–9, BLANK, DASH, E.
- Blanking: digits above the most significant nonzero digit are BLANK. Digit 0 is never blanked for non-negative values.
- Sign: if `neg` and magnitude≠0, DASH is placed at (MS nonzero digit index + 1).
- If that index would be 8: `err`=1, display shows E on digit 0, all others BLANK.
- `neg` with magnitude 0: DASH on digit 0, others BLANK, `err`=0.
- Scan: divider counts 0..SCAN_DIV-1. At terminal count the digit index increments 0→7→0. `an` = ~(1<<index); `seg` = decode(code[index]).
- Segment patterns: BLANK → 8'hFF; DASH → g only (8'hBF); E → a,d,e,f,g (8'h86).
- Scan runs continuously, independent of the FSM.

## Timing

- Reset values:
  - State IDLE; `busy`=0, `err`=0.
  - Digit index 0, divider 0, `an`=8'hFE.
  - All display codes BLANK, so `seg`=8'hFF.
- `load` sampled at edge k → `busy`=1 from after edge k.
- CONV occupies edges k+1..k+25; FIX occurs at edge k+26.
- New display codes and `err` are visible, and `busy`=0, after edge k+26. Total latency is 26 cycles.
- Earliest accepted reload is edge k+27.
- `an`/`seg` are registered and change only at divider terminal count (and at reset); the new digit appears one cycle after terminal count.
- `rst` during CONV aborts the conversion, blanks the display, and clears `busy` at the next edge.
- `load` coincident with `rst`: reset wins.

## Structure

- Package `calc_disp_pkg`:
  - 4-bit digit code constants `DIG_BLANK`=4'hA, `DIG_DASH`=4'hB, `DIG_E`=4'hC.
  - FSM state encoding.
  - Constant `N_DIG`=8.
- Sub-module `seg7_decode`: combinational 4-bit code → active-low 8-bit pattern.
- Top contains the FSM, the double-dabble datapath, FIX logic and the scan divider.

## Test plan

- Reset, then run 9×SCAN_DIV cycles with SCAN_DIV=4 → `an` cycles FE,FD,FB,…,7F,FE; `seg`=FF throughout; `busy`=0.
- `load` with `abs_num`=1234, `neg`=0 → `busy` high exactly 26 cycles; digits 3..0 = 1,2,3,4; digits 7..4 BLANK; `err`=0.
- `abs_num`=16_777_216, `neg`=1 → digits 7..0 = DASH,1,6,7,7,7,2,1,6 is impossible, so expect `err`=1, digit 0 = E (`seg`=86), others FF. Then `abs_num`=9_999_999, `neg`=1 → digit 7 DASH, `err`=0.
- `abs_num`=0, `neg`=1 → digit 0 `seg`=BF, rest FF. Then `abs_num`=0, `neg`=0 → digit 0 shows 0 (`seg`=C0).
- Second `load` asserted 5 cycles after the first, with a different value → ignored; display shows only the first value, and `busy` drops at first load +26.
- `rst` asserted 10 cycles into CONV → next cycle `busy`=0, all digits FF. A following `load` with 42 converts normally in 26 cycles.
